// File: rtl/glitch_defs_pkg.sv
// Shared glitch_wb definitions: register addresses, host opcodes, response codes
// and the command-master state type.
package glitch_defs;

    localparam logic [3:0] GLITCH_STATUS  = 4'h0;
    localparam logic [3:0] GLITCH_QUEUE_0 = 4'h4;
    localparam logic [3:0] GLITCH_QUEUE_1 = 4'h5;
    localparam logic [3:0] GLITCH_QUEUE_2 = 4'h6;
    localparam logic [3:0] GLITCH_QUEUE_3 = 4'h7;

    localparam logic [7:0] OP_WRITE_ENTRY = 8'h01;
    localparam logic [7:0] OP_READ_STATUS = 8'h02;

    localparam logic [7:0] RSP_OK      = 8'h00;
    localparam logic [7:0] RSP_INVALID = 8'hFE;
    localparam logic [7:0] RSP_TIMEOUT = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_BUS,
        ST_RESP
    } mstate_e;

    // Payload byte n lands in GLITCH_QUEUE_n; the queue registers are contiguous.
    function automatic logic [3:0] queue_addr(input logic [1:0] idx);
        return GLITCH_QUEUE_0 + {2'b00, idx};
    endfunction

endpackage

// File: rtl/glitch_wbm_bus.sv
// Single Wishbone transfer engine: registered stb/we/adr/dat held until ack.
// Optional ack timeout enabled by defining GLITCH_WBM_TIMEOUT_EN.
module glitch_wbm_bus #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic [3:0] addr_i,
    input  logic       we_i,
    input  logic [7:0] wdata_i,
    output logic       done_o,
    output logic [7:0] rdata_o,
    output logic       err_o,
    output logic [5:2] adr_o,
    output logic [7:0] dat_o,
    input  logic [7:0] dat_i,
    output logic       we_o,
    output logic       stb_o,
    input  logic       ack_i
);

    logic       stb_q, stb_d;
    logic       we_q, we_d;
    logic [3:0] adr_q, adr_d;
    logic [7:0] dat_q, dat_d;
    logic       timeout;

`ifdef GLITCH_WBM_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;

    // cnt_q holds the number of stb-high cycles already completed without ack.
    always_comb begin
        cnt_d = cnt_q;
        if (!stb_q)
            cnt_d = '0;
        else if (!ack_i)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign timeout = stb_q && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

    always_comb begin
        stb_d = stb_q;
        we_d  = we_q;
        adr_d = adr_q;
        dat_d = dat_q;
        if (stb_q) begin
            if (ack_i || timeout)
                stb_d = 1'b0;
        end else if (start_i) begin
            stb_d = 1'b1;
            we_d  = we_i;
            adr_d = addr_i;
            dat_d = wdata_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stb_q <= 1'b0;
            we_q  <= 1'b0;
            adr_q <= '0;
            dat_q <= '0;
        end else begin
            stb_q <= stb_d;
            we_q  <= we_d;
            adr_q <= adr_d;
            dat_q <= dat_d;
        end
    end

    assign done_o  = stb_q && (ack_i || timeout);
    assign err_o   = stb_q && timeout && !ack_i;
    assign rdata_o = dat_i;
    assign stb_o   = stb_q;
    assign we_o    = we_q;
    assign adr_o   = adr_q;
    assign dat_o   = dat_q;

endmodule

// File: rtl/glitch_wb_master.sv
// Host byte-command to Wishbone master for the glitch_wb register slave.
// Ack timeout (response 0xFF) compiled in when GLITCH_WBM_TIMEOUT_EN is defined.
module glitch_wb_master
    import glitch_defs::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       cmd_valid_i,
    input  logic [7:0] cmd_data_i,
    output logic       cmd_ready_o,
    output logic       rsp_valid_o,
    output logic [7:0] rsp_data_o,
    input  logic       rsp_ready_i,
    output logic [5:2] adr_o,
    output logic [7:0] dat_o,
    input  logic [7:0] dat_i,
    output logic       we_o,
    output logic       stb_o,
    input  logic       ack_i
);

    mstate_e         state_q, state_d;
    logic [1:0]      idx_q, idx_d;
    logic [3:0][7:0] pay_q, pay_d;
    logic            is_rd_q, is_rd_d;
    logic [7:0]      rsp_q, rsp_d;
    logic            start_q, start_d;
    logic            run_q;
    logic            accept;
    logic            bus_done, bus_err;
    logic [7:0]      bus_rdata;

    // run_q keeps cmd_ready_o low until the first clock after reset release.
    assign cmd_ready_o = run_q && (state_q == ST_IDLE || state_q == ST_COLLECT);
    assign accept      = cmd_valid_i && cmd_ready_o;
    assign rsp_valid_o = (state_q == ST_RESP);
    assign rsp_data_o  = rsp_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pay_d   = pay_q;
        is_rd_d = is_rd_q;
        rsp_d   = rsp_q;
        start_d = start_q;
        case (state_q)
            ST_IDLE: if (accept) begin
                idx_d = '0;
                if (cmd_data_i == OP_WRITE_ENTRY) begin
                    state_d = ST_COLLECT;
                end else if (cmd_data_i == OP_READ_STATUS) begin
                    state_d = ST_BUS;
                    is_rd_d = 1'b1;
                    start_d = 1'b1;
                end else begin
                    state_d = ST_RESP;
                    rsp_d   = RSP_INVALID;
                end
            end
            ST_COLLECT: if (accept) begin
                pay_d[idx_q] = cmd_data_i;
                idx_d        = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    state_d = ST_BUS;
                    is_rd_d = 1'b0;
                    start_d = 1'b1;
                end
            end
            ST_BUS: begin
                start_d = 1'b0;
                // Next write is requested only after done so the bus sees an idle cycle.
                if (bus_done) begin
                    if (bus_err) begin
                        state_d = ST_RESP;
                        rsp_d   = RSP_TIMEOUT;
                    end else if (is_rd_q) begin
                        state_d = ST_RESP;
                        rsp_d   = bus_rdata;
                    end else if (idx_q == 2'd3) begin
                        state_d = ST_RESP;
                        rsp_d   = RSP_OK;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        start_d = 1'b1;
                    end
                end
            end
            ST_RESP: if (rsp_ready_i) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            pay_q   <= '0;
            is_rd_q <= 1'b0;
            rsp_q   <= '0;
            start_q <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pay_q   <= pay_d;
            is_rd_q <= is_rd_d;
            rsp_q   <= rsp_d;
            start_q <= start_d;
            run_q   <= 1'b1;
        end
    end

    glitch_wbm_bus #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_bus (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (start_q),
        .addr_i  (is_rd_q ? GLITCH_STATUS : queue_addr(idx_q)),
        .we_i    (!is_rd_q),
        .wdata_i (pay_q[idx_q]),
        .done_o  (bus_done),
        .rdata_o (bus_rdata),
        .err_o   (bus_err),
        .adr_o   (adr_o),
        .dat_o   (dat_o),
        .dat_i   (dat_i),
        .we_o    (we_o),
        .stb_o   (stb_o),
        .ack_i   (ack_i)
    );

endmodule

// File: tb/tb_glitch_wb_master.sv
// Bench for glitch_wb_master: transaction-level model, random slave ack timing,
// random host gaps and response back-pressure.
`timescale 1ns/1ps
module tb_glitch_wb_master;
    import glitch_defs::*;

    localparam int unsigned TO = 16;

    typedef logic [7:0] bq_t [$];
    typedef struct {
        logic [3:0] adr;
        logic       we;
        logic [7:0] dat;
    } xfer_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [7:0] cmd_data = 8'h00;
    logic       cmd_ready;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_ready = 1'b0;
    logic [5:2] adr;
    logic [7:0] dat_o_w;
    logic [7:0] dat_i_w = 8'h00;
    logic       we, stb;
    logic       ack = 1'b0;

    always #5 clk = ~clk;

    glitch_wb_master #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk), .rst_i(rst),
        .cmd_valid_i(cmd_valid), .cmd_data_i(cmd_data), .cmd_ready_o(cmd_ready),
        .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data), .rsp_ready_i(rsp_ready),
        .adr_o(adr), .dat_o(dat_o_w), .dat_i(dat_i_w),
        .we_o(we), .stb_o(stb), .ack_i(ack)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // ---------------- slave model ----------------
    logic [7:0] status_val = 8'h01;
    logic [7:0] qregs [4] = '{8'h00, 8'h00, 8'h00, 8'h00};
    bit         ack_en = 1'b1;
    int         wcnt = 0;

    always @(posedge clk) begin
        #1;
        if (rst || !ack_en) begin
            ack = 1'b0;
        end else if (stb) begin
            if (wcnt == 0) ack = 1'b1;
            else begin ack = 1'b0; wcnt--; end
        end else begin
            ack  = ($urandom_range(0, 7) == 0);
            wcnt = $urandom_range(0, 3);
        end
        dat_i_w = (stb && ack && !we) ? status_val : 8'($urandom);
    end

    // ---------------- host response consumer ----------------
    bit rsp_hold = 1'b0;
    always @(posedge clk) begin
        #1;
        rsp_ready = rsp_hold ? 1'b0 : ($urandom_range(0, 2) != 0);
    end

    // ---------------- reference model queues ----------------
    xfer_t      exp_x[$];
    logic [7:0] exp_rsp[$];
    logic [7:0] last_rsp = 8'h00;
    int         n_xfers = 0;
    int         stb_high_cycles = 0;

    task automatic model_cmd(input bq_t b);
        xfer_t x;
        if (b[0] == 8'h01) begin
            if (ack_en) begin
                for (int i = 0; i < 4; i++) begin
                    x.adr = GLITCH_QUEUE_0 + 4'(i);
                    x.we  = 1'b1;
                    x.dat = b[i+1];
                    exp_x.push_back(x);
                end
                exp_rsp.push_back(8'h00);
            end else begin
                exp_rsp.push_back(8'hFF);
            end
        end else if (b[0] == 8'h02) begin
            if (ack_en) begin
                x.adr = GLITCH_STATUS;
                x.we  = 1'b0;
                x.dat = 8'h00;
                exp_x.push_back(x);
                exp_rsp.push_back(status_val);
            end else begin
                exp_rsp.push_back(8'hFF);
            end
        end else begin
            exp_rsp.push_back(8'hFE);
        end
    endtask

    // ---------------- compare process ----------------
    logic       p_stb = 1'b0, p_ack = 1'b0, p_we = 1'b0, p_rv = 1'b0, p_rr = 1'b0;
    logic [3:0] p_adr = '0;
    logic [7:0] p_dat = '0, p_rsp = '0;
    xfer_t      e;
    int         qi;

    always @(negedge clk) begin
        if (rst) begin
            p_stb = 1'b0; p_ack = 1'b0; p_rv = 1'b0; p_rr = 1'b0;
        end else begin
            if (stb) stb_high_cycles++;
            if (p_stb && !p_ack) begin
`ifndef GLITCH_WBM_TIMEOUT_EN
                check("stb_hold", stb, 1'b1);
`endif
                if (stb) check("bus_stable", {we, adr, dat_o_w}, {p_we, p_adr, p_dat});
            end
            if (p_stb && p_ack) check("stb_gap", stb, 1'b0);
            if (stb || rsp_valid) check("ready_busy", cmd_ready, 1'b0);
            if (stb && ack) begin
                n_xfers++;
                if (exp_x.size() == 0) begin
                    fail_now($sformatf("unexpected_xfer adr=0x%0h we=%0b dat=0x%0h", adr, we, dat_o_w));
                end else begin
                    e = exp_x.pop_front();
                    check("xfer_adr", adr, e.adr);
                    check("xfer_we", we, e.we);
                    if (e.we) check("xfer_dat", dat_o_w, e.dat);
                end
                qi = int'(adr) - int'(GLITCH_QUEUE_0);
                if (we && qi >= 0 && qi < 4) qregs[qi] = dat_o_w;
            end
            if (p_rv && !p_rr) begin
                check("rsp_valid_hold", rsp_valid, 1'b1);
                check("rsp_data_hold", rsp_data, p_rsp);
            end
            if (rsp_valid && rsp_ready) begin
                last_rsp = rsp_data;
                if (exp_rsp.size() == 0) fail_now("unexpected_rsp");
                else check("rsp_data", rsp_data, exp_rsp.pop_front());
            end
            p_stb = stb; p_ack = ack; p_we = we; p_adr = adr; p_dat = dat_o_w;
            p_rv = rsp_valid; p_rr = rsp_ready; p_rsp = rsp_data;
        end
    end

    // ---------------- host driver ----------------
    task automatic send_bytes(input bq_t b, input bit gaps, output int cycles);
        int  i;
        bit  acc;
        i = 0;
        cycles = 0;
        while (i < b.size()) begin
            if (gaps && $urandom_range(0, 3) == 0) cmd_valid = 1'b0;
            else begin cmd_valid = 1'b1; cmd_data = b[i]; end
            @(negedge clk);
            acc = cmd_valid && cmd_ready;
            @(posedge clk); #1;
            cycles++;
            if (acc) i++;
            if (cycles > 2000) begin fail_now("cmd_accept_timeout"); break; end
        end
        cmd_valid = 1'b0;
    endtask

    task automatic issue(input bq_t b, input bit gaps, output int cycles);
        model_cmd(b);
        send_bytes(b, gaps, cycles);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_rsp.size() != 0 || rsp_valid) && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 1000) fail_now("response_timeout");
    endtask

    task automatic mk_write(input logic [7:0] b0, b1, b2, b3, output bq_t q);
        q.delete();
        q.push_back(8'h01); q.push_back(b0); q.push_back(b1); q.push_back(b2); q.push_back(b3);
    endtask

    task automatic mk_one(input logic [7:0] op, output bq_t q);
        q.delete();
        q.push_back(op);
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t q;
        int  cyc, base, n, snap;
        logic [7:0] qs [4];

        // reset state
        repeat (2) @(negedge clk);
        check("rst_stb", stb, 1'b0);
        check("rst_we", we, 1'b0);
        check("rst_adr", adr, 4'h0);
        check("rst_dat", dat_o_w, 8'h00);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_data", rsp_data, 8'h00);
        check("rst_cmd_ready", cmd_ready, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("ready_before_clk", cmd_ready, 1'b0);
        @(posedge clk); #1;
        check("ready_after_clk", cmd_ready, 1'b1);

        // write entry without gaps: no bubble, writes land in QUEUE_0..3
        mk_write(8'h04, 8'h02, 8'h02, 8'h00, q);
        issue(q, 1'b0, cyc);
        check("no_bubble_cycles", 32'(cyc), 32'd5);
        wait_idle();
        check("q0", qregs[0], 8'h04);
        check("q1", qregs[1], 8'h02);
        check("q2", qregs[2], 8'h02);
        check("q3", qregs[3], 8'h00);
        check("write_rsp", last_rsp, 8'h00);

        // status read on idle slave
        status_val = 8'h01;
        base = n_xfers;
        mk_one(8'h02, q);
        issue(q, 1'b0, cyc);
        wait_idle();
        check("status_rsp", last_rsp, 8'h01);
        check("status_xfers", 32'(n_xfers - base), 32'd1);

        // invalid opcode: no bus activity
        snap = stb_high_cycles;
        mk_one(8'h7A, q);
        issue(q, 1'b0, cyc);
        wait_idle();
        check("invalid_rsp", last_rsp, 8'hFE);
        check("invalid_no_stb", 32'(stb_high_cycles - snap), 32'd0);

        // response back-pressure for 20 cycles with the next opcode pending
        rsp_hold = 1'b1;
        status_val = 8'h5C;
        mk_one(8'h02, q);
        issue(q, 1'b0, cyc);
        fork
            begin
                int k;
                k = 0;
                while (!rsp_valid && k < 200) begin @(posedge clk); #1; k++; end
                if (k >= 200) fail_now("hold_rsp_never_valid");
                repeat (20) @(posedge clk);
                #1 rsp_hold = 1'b0;
            end
        join_none
        mk_one(8'h33, q);
        issue(q, 1'b0, cyc);
        check("pending_byte_waited", 32'(cyc > 20), 32'd1);
        wait_idle();
        check("pending_byte_rsp", last_rsp, 8'hFE);

        // reset after two of four writes
        mk_write(8'hA1, 8'hB2, 8'hC3, 8'hD4, q);
        base = n_xfers;
        issue(q, 1'b1, cyc);
        n = 0;
        while (n_xfers < base + 2 && n < 500) begin @(posedge clk); #1; n++; end
        if (n >= 500) fail_now("two_writes_timeout");
        n = 0;
        while (!stb && n < 50) begin @(posedge clk); #1; n++; end
        #1 rst = 1'b1;
        #1;
        check("midrst_stb", stb, 1'b0);
        check("midrst_cmd_ready", cmd_ready, 1'b0);
        check("midrst_rsp_valid", rsp_valid, 1'b0);
        exp_x.delete();
        exp_rsp.delete();
        for (int i = 0; i < 4; i++) qs[i] = qregs[i];
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        status_val = 8'h01;
        mk_one(8'h02, q);
        issue(q, 1'b0, cyc);
        wait_idle();
        check("post_rst_status", last_rsp, 8'h01);
        check("post_rst_q", {qregs[0], qregs[1], qregs[2], qregs[3]}, {qs[0], qs[1], qs[2], qs[3]});

        // random traffic
        for (int t = 0; t < 40; t++) begin
            int sel;
            status_val = 8'($urandom);
            sel = $urandom_range(0, 19);
            if (sel < 9) mk_write(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), q);
            else if (sel < 16) mk_one(8'h02, q);
            else begin
                logic [7:0] op;
                op = 8'($urandom);
                if (op == 8'h01 || op == 8'h02) op = 8'h80;
                mk_one(op, q);
            end
            issue(q, 1'b1, cyc);
            wait_idle();
        end
        check("all_xfers_consumed", 32'(exp_x.size()), 32'd0);

`ifdef GLITCH_WBM_TIMEOUT_EN
        ack_en = 1'b0;
        snap = stb_high_cycles;
        mk_write(8'h11, 8'h22, 8'h33, 8'h44, q);
        issue(q, 1'b0, cyc);
        wait_idle();
        check("to_write_stb_cycles", 32'(stb_high_cycles - snap), 32'd16);
        check("to_write_rsp", last_rsp, 8'hFF);
        snap = stb_high_cycles;
        mk_one(8'h02, q);
        issue(q, 1'b0, cyc);
        wait_idle();
        check("to_read_stb_cycles", 32'(stb_high_cycles - snap), 32'd16);
        check("to_read_rsp", last_rsp, 8'hFF);
        ack_en = 1'b1;
        status_val = 8'h01;
        mk_one(8'h02, q);
        issue(q, 1'b0, cyc);
        wait_idle();
        check("to_recover_rsp", last_rsp, 8'h01);
`endif

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
